// File: rtl/sram_spi_pkg.sv
// Shared definitions for the 23LC1024 SPI SRAM responder: the opcodes it
// answers and the transaction state encoding.
package sram_spi_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] OP_READ  = 8'h03;
  localparam logic [BYTE_W-1:0] OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD_DATA,
    WR_DATA,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave bit engine: synchronizes SCK/CSn/SI onto clk, detects SCK
// edges, shifts received bits in MSB first and transmit bits out MSB first.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   csn_pin, sck_pin, si_pin raw asynchronous SPI pins
//   load_c, load_data        load a byte into the transmit register (bit 7 on so)
//   tx_clr_c                 clear the transmit register (forces so low)
//   cs_n, cs_fall            synchronized chip select and its falling-edge strobe
//   so                       serial output (MSB of transmit register)
//   byte_done_c, rx_byte_c   strobe and value of a completed received byte
module spi_slave_shifter
  import sram_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csn_pin,
  input  logic              sck_pin,
  input  logic              si_pin,
  input  logic              load_c,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              tx_clr_c,
  output logic              cs_n,
  output logic              cs_fall,
  output logic              so,
  output logic              byte_done_c,
  output logic [BYTE_W-1:0] rx_byte_c
);

  // Synchronizer chain, one 3-bit word per stage: {sck, csn, si}
  logic [2:0]        sync_q [SYNC_STAGES];
  logic              sck_s, csn_s, si_s;
  logic              sck_q, rise_q, fall_q, si_q;
  logic [2:0]        cnt_q;
  logic [BYTE_W-1:0] rx_q, tx_q;

  assign {sck_s, csn_s, si_s} = sync_q[SYNC_STAGES-1];

  assign rx_byte_c   = {rx_q[BYTE_W-2:0], si_q};
  assign byte_done_c = rise_q & ~cs_n & (cnt_q == 3'd7);
  assign so          = tx_q[BYTE_W-1];

  // Edge strobes, cs_n and si_q are all registered from the same sync sample,
  // so a CSn rise coinciding with an SCK edge is seen together and CSn wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      sck_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      si_q    <= 1'b0;
      // Reset low so a CSn already held low across reset is not taken as a
      // fresh falling edge; a new transaction needs a real high-then-low.
      cs_n    <= 1'b0;
      cs_fall <= 1'b0;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
    end else begin
      sync_q[0] <= {sck_pin, csn_pin, si_pin};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      sck_q   <= sck_s;
      rise_q  <= sck_s & ~sck_q;
      fall_q  <= ~sck_s & sck_q;
      si_q    <= si_s;
      cs_n    <= csn_s;
      cs_fall <= cs_n & ~csn_s;

      // Deselect discards any partial byte
      if (cs_n) begin
        cnt_q <= '0;
        rx_q  <= '0;
      end else if (rise_q) begin
        cnt_q <= cnt_q + 3'd1;
        rx_q  <= rx_byte_c;
      end

      // The falling edge right after bit 0 must not shift: the freshly loaded
      // byte already presents its bit 7.
      if (tx_clr_c) begin
        tx_q <= '0;
      end else if (load_c) begin
        tx_q <= load_data;
      end else if (fall_q && !cs_n && cnt_q != 3'd0) begin
        tx_q <= {tx_q[BYTE_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/sram_23lc1024_responder.sv
// SPI-slave emulation of a 23LC1024 serial SRAM answering READ (0x03) and
// WRITE (0x02) with byte accesses on a local synchronous RAM port.
// Build option: SRAM_SEQ_MODE_EN selects sequential (burst, auto-increment)
// mode; without it the part works in byte mode (one data byte per select).
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   CSn, SCK, SI        SPI slave inputs (asynchronous to clk)
//   SO, so_en           serial data out and its pad output enable
//   mem_addr/wdata/we   RAM write port, one-cycle strobe
//   mem_re, mem_rdata   RAM read strobe; data valid the cycle after mem_re
//   busy                a transaction is selected
//   cmd_err             one-cycle pulse on an unsupported opcode
module sram_23lc1024_responder
  import sram_spi_pkg::*;
#(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CSn,
  input  logic              SCK,
  input  logic              SI,
  output logic              SO,
  output logic              so_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  logic              cs_n, cs_fall, byte_done_c, load_c, tx_clr_c;
  logic [BYTE_W-1:0] rx_byte_c;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n, mem_addr_n;
  logic [1:0]        abyte_q, abyte_n;
  logic              rd_sel_q, rd_sel_n, rd_pend_q;
  logic [BYTE_W-1:0] mem_wdata_n;
  logic              mem_we_n, mem_re_n, so_en_n, cmd_err_n, busy_n;

  spi_slave_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .csn_pin     (CSn),
    .sck_pin     (SCK),
    .si_pin      (SI),
    .load_c      (load_c),
    .load_data   (mem_rdata),
    .tx_clr_c    (tx_clr_c),
    .cs_n        (cs_n),
    .cs_fall     (cs_fall),
    .so          (SO),
    .byte_done_c (byte_done_c),
    .rx_byte_c   (rx_byte_c)
  );

  // Next-state, address and RAM-port decisions
  always_comb begin
    state_n     = state_q;
    addr_n      = addr_q;
    abyte_n     = abyte_q;
    rd_sel_n    = rd_sel_q;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_we_n    = 1'b0;
    mem_re_n    = 1'b0;
    cmd_err_n   = 1'b0;
    so_en_n     = so_en;
    load_c      = 1'b0;

    if (cs_n) begin
      state_n = IDLE;
      abyte_n = '0;
      so_en_n = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (cs_fall) state_n = CMD;
        CMD: if (byte_done_c) begin
          if (rx_byte_c == OP_READ) begin
            state_n  = ADDR;
            rd_sel_n = 1'b1;
          end else if (rx_byte_c == OP_WRITE) begin
            state_n  = ADDR;
            rd_sel_n = 1'b0;
          end else begin
            state_n   = IGNORE;
            cmd_err_n = 1'b1;
          end
        end
        // Bytes shift in MSB first; bits above ADDR_W fall off the top
        ADDR: if (byte_done_c) begin
          addr_n  = {addr_q[ADDR_W-9:0], rx_byte_c};
          abyte_n = abyte_q + 2'd1;
          if (abyte_q == 2'd2) begin
            abyte_n = '0;
            if (rd_sel_q) begin
              state_n    = RD_DATA;
              mem_re_n   = 1'b1;
              mem_addr_n = addr_n;
            end else begin
              state_n = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          // Read data arrives one cycle after the strobe
          if (rd_pend_q) begin
            load_c  = 1'b1;
            so_en_n = 1'b1;
          end
          if (byte_done_c) begin
`ifdef SRAM_SEQ_MODE_EN
            addr_n     = addr_q + ADDR_W'(1);
            mem_re_n   = 1'b1;
            mem_addr_n = addr_n;
`else
            state_n = IGNORE;
            so_en_n = 1'b0;
`endif
          end
        end
        WR_DATA: if (byte_done_c) begin
          mem_we_n    = 1'b1;
          mem_wdata_n = rx_byte_c;
          mem_addr_n  = addr_q;
`ifdef SRAM_SEQ_MODE_EN
          addr_n = addr_q + ADDR_W'(1);
`else
          state_n = IGNORE;
`endif
        end
        IGNORE: state_n = IGNORE;
        default: state_n = IDLE;
      endcase
    end

    tx_clr_c = ~so_en_n;
    busy_n   = (state_n != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      abyte_q   <= '0;
      rd_sel_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      so_en     <= 1'b0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state_q   <= state_n;
      addr_q    <= addr_n;
      abyte_q   <= abyte_n;
      rd_sel_q  <= rd_sel_n;
      rd_pend_q <= mem_re;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_we    <= mem_we_n;
      mem_re    <= mem_re_n;
      so_en     <= so_en_n;
      busy      <= busy_n;
      cmd_err   <= cmd_err_n;
    end
  end

endmodule

// File: tb/tb_sram_23lc1024_responder.sv
// Self-checking bench for sram_23lc1024_responder: an SPI master drives a
// table of transactions and a few hand-written corner cases against a
// behavioral synchronous RAM. Follows SRAM_SEQ_MODE_EN like the design.
module tb_sram_23lc1024_responder;

  localparam int unsigned ADDR_W = 17;
  localparam int          HALF   = 6;   // clk cycles per SCK phase
`ifdef SRAM_SEQ_MODE_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, CSn, SCK, SI, SO, so_en, mem_we, mem_re, busy, cmd_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_23lc1024_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .CSn       (CSn),
    .SCK       (SCK),
    .SI        (SI),
    .SO        (SO),
    .so_en     (so_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          nbytes;
    logic [7:0]  d0, d1;
    int          exp_we, exp_re, exp_err;
  } txn_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } wr_t;

  typedef struct {
    logic [7:0] so;
    logic [7:0] en;
  } byte_exp_t;

  logic [7:0] ram   [1<<ADDR_W];
  logic [7:0] model [1<<ADDR_W];
  wr_t        wr_q  [$];
  byte_exp_t  exp_q [$];
  txn_t       vec   [9];

  int n_checks = 0, n_fail = 0;
  int we_cnt = 0, re_cnt = 0, err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous RAM behind the responder
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  // Port monitor: writes are checked against the scoreboard as they occur
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (mem_re) re_cnt++;
      if (cmd_err) err_cnt++;
      if (mem_we) begin
        we_cnt++;
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
        end else begin
          e = wr_q.pop_front();
          check("write addr/data", {7'd0, mem_addr, mem_wdata}, {7'd0, e.a, e.d});
        end
      end
    end
  end

  // Mode-0 master: SI set while SCK low, SO sampled just before the rise
  task automatic spi_bits(input logic [7:0] b, input int nbits,
                          output logic [7:0] rx, output logic [7:0] en);
    rx = '0;
    en = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      SI = b[i];
      repeat (HALF) @(negedge clk);
      rx[i] = SO;
      en[i] = so_en;
      SCK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCK = 1'b0;
    end
  endtask

  task automatic xfer_byte(input logic [7:0] b, input logic [7:0] exp_so,
                           input logic [7:0] exp_en, input string tag);
    byte_exp_t  e;
    logic [7:0] r, en;
    e.so = exp_so;
    e.en = exp_en;
    exp_q.push_back(e);
    spi_bits(b, 8, r, en);
    e = exp_q.pop_front();
    check({tag, " SO"}, {24'd0, r}, {24'd0, e.so});
    check({tag, " so_en"}, {24'd0, en}, {24'd0, e.en});
  endtask

  task automatic header(input logic [7:0] op, input logic [23:0] addr, input string tag);
    xfer_byte(op, 8'h00, 8'h00, {tag, " op"});
    xfer_byte(addr[23:16], 8'h00, 8'h00, {tag, " a2"});
    xfer_byte(addr[15:8], 8'h00, 8'h00, {tag, " a1"});
    xfer_byte(addr[7:0], 8'h00, 8'h00, {tag, " a0"});
  endtask

  task automatic end_select(input string tag);
    repeat (HALF) @(negedge clk);
    CSn = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check({tag, " busy after CSn high"}, {31'd0, busy}, 32'd0);
    check({tag, " so_en after CSn high"}, {31'd0, so_en}, 32'd0);
  endtask

  task automatic run_txn(input txn_t t, input string tag);
    int                we0, re0, err0;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    bit                live;
    wr_t               w;
    we0  = we_cnt;
    re0  = re_cnt;
    err0 = err_cnt;
    CSn  = 1'b0;
    repeat (HALF) @(negedge clk);
    check({tag, " busy selected"}, {31'd0, busy}, 32'd1);
    header(t.op, t.addr, tag);
    for (int k = 0; k < t.nbytes; k++) begin
      a    = t.addr[ADDR_W-1:0] + ADDR_W'(k);
      d    = (k == 0) ? t.d0 : t.d1;
      live = (k == 0) || SEQ;
      if (t.op == 8'h02) begin
        if (live) begin
          w.a = a;
          w.d = d;
          wr_q.push_back(w);
          model[a] = d;
        end
        xfer_byte(d, 8'h00, 8'h00, {tag, " wdata"});
      end else if (t.op == 8'h03) begin
        xfer_byte(8'h00, live ? model[a] : 8'h00, live ? 8'hFF : 8'h00, {tag, " rdata"});
      end else begin
        xfer_byte(d, 8'h00, 8'h00, {tag, " ignored"});
      end
    end
    end_select(tag);
    check({tag, " writes pending"}, wr_q.size(), 32'd0);
    check({tag, " mem_we count"}, we_cnt - we0, t.exp_we);
    check({tag, " mem_re count"}, re_cnt - re0, t.exp_re);
    check({tag, " cmd_err count"}, err_cnt - err0, t.exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t       t;
    logic [7:0] r, en;
    int         we0;

    rst = 1'b1;
    CSn = 1'b1;
    SCK = 1'b0;
    SI  = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i]   = 8'(i * 7 + 1);
      model[i] = ram[i];
    end
    ram[17'h00456]   = 8'h3C;
    model[17'h00456] = 8'h3C;

    //          op     addr          n  d0     d1     we             re               err
    vec[0] = '{8'h02, 24'h000123, 1, 8'hA5, 8'h00, 1,             0,               0};
    vec[1] = '{8'h03, 24'h000456, 1, 8'h00, 8'h00, 0,             SEQ ? 2 : 1,     0};
    vec[2] = '{8'h02, 24'h01FFFF, 2, 8'h11, 8'h22, SEQ ? 2 : 1,   0,               0};
    vec[3] = '{8'h03, 24'h01FFFF, 2, 8'h00, 8'h00, 0,             SEQ ? 3 : 1,     0};
    vec[4] = '{8'h05, 24'h000123, 1, 8'hFF, 8'h00, 0,             0,               1};
    vec[5] = '{8'h03, 24'h000123, 1, 8'h00, 8'h00, 0,             SEQ ? 2 : 1,     0};
    vec[6] = '{8'h02, 24'hFE0010, 1, 8'h5A, 8'h00, 1,             0,               0};
    vec[7] = '{8'h03, 24'h000010, 1, 8'h00, 8'h00, 0,             SEQ ? 2 : 1,     0};
    vec[8] = '{8'h03, 24'h000000, 1, 8'h00, 8'h00, 0,             SEQ ? 2 : 1,     0};

    repeat (4) @(negedge clk);
    check("reset outputs", {1'b0, SO, so_en, mem_we, mem_re, mem_addr, mem_wdata, busy, cmd_err}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 9; i++) run_txn(vec[i], $sformatf("v%0d", i));

    // Deselect after 5 bits of a write data byte: nothing is written
    we0 = we_cnt;
    CSn = 1'b0;
    repeat (HALF) @(negedge clk);
    header(8'h02, 24'h000200, "abort");
    spi_bits(8'hC3, 5, r, en);
    end_select("abort");
    check("abort mem_we count", we_cnt - we0, 32'd0);
    t = '{8'h02, 24'h000200, 1, 8'h77, 8'h00, 1, 0, 0};
    run_txn(t, "after_abort_wr");
    t = '{8'h03, 24'h000200, 1, 8'h00, 8'h00, 0, SEQ ? 2 : 1, 0};
    run_txn(t, "after_abort_rd");

    // Reset in the address phase with CSn held low
    we0 = we_cnt;
    CSn = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer_byte(8'h02, 8'h00, 8'h00, "rst_mid op");
    xfer_byte(8'h00, 8'h00, 8'h00, "rst_mid a2");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid outputs", {1'b0, SO, so_en, mem_we, mem_re, mem_addr, mem_wdata, busy, cmd_err}, 32'd0);
    rst = 1'b0;
    xfer_byte(8'h03, 8'h00, 8'h00, "rst_mid a1");
    xfer_byte(8'h00, 8'h00, 8'h00, "rst_mid a0");
    xfer_byte(8'h99, 8'h00, 8'h00, "rst_mid data");
    check("rst_mid busy while CSn low", {31'd0, busy}, 32'd0);
    end_select("rst_mid");
    check("rst_mid mem_we count", we_cnt - we0, 32'd0);
    t = '{8'h03, 24'h000300, 1, 8'h00, 8'h00, 0, SEQ ? 2 : 1, 0};
    run_txn(t, "after_rst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
